fetch_queue: RTL and testbench

- Prefetch FIFO between the instruction memory A-port and the if_id decoder.
- Decouples fetch from decode so that a conveyor stall does not drop fetched words.
- Holds fetched instructions with their PC. Presents the oldest entry to if_id.
- Back-pressures pc_adder and is flushed when a jump is taken.

---
 rtl/fetch_queue.sv | 145 ++++++++++++++
 tb/tb_fetch_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Prefetch FIFO sitting between the instruction memory A-port and the if_id
// decoder. Fetched words are stored together with their PC so that a decode
// stall never drops a word that is already on its way out of inst_mem. The
// oldest entry is presented first-word-fall-through at the head. The queue
// back-pressures pc_adder and is emptied whenever a jump is taken.
//
// Parameters
//   DEPTH   number of entries (power of two, 2..16)
//   INST_W  instruction word width
//   PC_W    program counter width
//   PTR_W   pointer width, log2(DEPTH)
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   fetch_valid    fetch_inst/fetch_pc carry a valid word this cycle
//   fetch_inst     word read from inst_mem
//   fetch_pc       PC of fetch_inst
//   fetch_stop     hold request to pc_adder (high = hold PC)
//   conveyor_stop  decode stall, head is not consumed while high
//   jump_start     taken jump, discards every queued entry
//   command        head instruction, 0 (NOP) when empty
//   command_pc     PC of the head entry, 0 when empty
//   command_valid  head entry is valid
//   count          current occupancy, 0..DEPTH
//   overflow_err   sticky, a word arrived while the queue was full
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int INST_W = 32,
   parameter int PC_W   = 32,
   parameter int PTR_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_valid,
   input  logic [INST_W-1:0] fetch_inst,
   input  logic [PC_W-1:0]   fetch_pc,
   output logic              fetch_stop,
   input  logic              conveyor_stop,
   input  logic              jump_start,
   output logic [INST_W-1:0] command,
   output logic [PC_W-1:0]   command_pc,
   output logic              command_valid,
   output logic [PTR_W:0]    count,
   output logic              overflow_err
);

   localparam logic [PTR_W:0]   FULL_CNT   = (PTR_W+1)'(DEPTH);
   // One slot is kept free for the word already in flight from inst_mem.
   localparam logic [PTR_W:0]   ALMOST_CNT = (PTR_W+1)'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);

   // Storage is data only; its contents are irrelevant while count says empty.
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PC_W-1:0]   pc_mem   [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   logic [PTR_W-1:0] wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_next;
   logic [PTR_W:0]   count_next;
   logic             overflow_next;

   logic full;
   logic empty;
   logic push;
   logic pop;

   // Push/pop qualification. A flush suppresses both; a full queue refuses a
   // push even when the head is popped in the same cycle.
   always_comb begin
      full  = (count == FULL_CNT);
      empty = (count == '0);
      push  = fetch_valid && !full && !jump_start;
      pop   = !empty && !conveyor_stop && !jump_start;
   end

   // Next-state for pointers, occupancy and the sticky error flag.
   always_comb begin
      wr_ptr_next   = wr_ptr;
      rd_ptr_next   = rd_ptr;
      count_next    = count;
      overflow_next = overflow_err;

      if (fetch_valid && full) begin
         overflow_next = 1'b1;
      end

      if (jump_start) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_next = rd_ptr + PTR_ONE;
         end
         unique case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_next;
         rd_ptr       <= rd_ptr_next;
         count        <= count_next;
         overflow_err <= overflow_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wr_ptr] <= fetch_inst;
         pc_mem[wr_ptr]   <= fetch_pc;
      end
   end

   // Head is driven from registered state only; an empty queue shows a NOP
   // so uninitialised storage never leaks to the decoder.
   always_comb begin
      command_valid = !empty;
      command       = command_valid ? inst_mem[rd_ptr] : '0;
      command_pc    = command_valid ? pc_mem[rd_ptr]   : '0;
      // Held low while reset is asserted so pc_adder is free to restart.
      fetch_stop    = reset && ((count >= ALMOST_CNT) || conveyor_stop);
   end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   localparam int DEPTH  = 4;
   localparam int INST_W = 32;
   localparam int PC_W   = 32;
   localparam int PTR_W  = 2;

   logic              clk;
   logic              reset;
   logic              fetch_valid;
   logic [INST_W-1:0] fetch_inst;
   logic [PC_W-1:0]   fetch_pc;
   logic              fetch_stop;
   logic              conveyor_stop;
   logic              jump_start;
   logic [INST_W-1:0] command;
   logic [PC_W-1:0]   command_pc;
   logic              command_valid;
   logic [PTR_W:0]    count;
   logic              overflow_err;

   fetch_queue #(
      .DEPTH (DEPTH),
      .INST_W(INST_W),
      .PC_W  (PC_W),
      .PTR_W (PTR_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .fetch_valid  (fetch_valid),
      .fetch_inst   (fetch_inst),
      .fetch_pc     (fetch_pc),
      .fetch_stop   (fetch_stop),
      .conveyor_stop(conveyor_stop),
      .jump_start   (jump_start),
      .command      (command),
      .command_pc   (command_pc),
      .command_valid(command_valid),
      .count        (count),
      .overflow_err (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a queue of {pc, inst} pairs plus the sticky error flag.
   logic [63:0] mq[$];
   logic        m_ovf;

   int tests = 0;
   int fails = 0;
   int step_no = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s (step %0d): observed %0h expected %0h", tag, step_no, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check the head against the model before
   // the edge, then advance the model by the queue rules.
   task automatic step(input logic fv, input logic [31:0] inst, input logic [31:0] pc,
                       input logic cs, input logic js,
                       output logic did_pop, output logic [31:0] pop_val,
                       output logic did_push);
      logic full_m;
      logic [63:0] head;
      fetch_valid   = fv;
      fetch_inst    = inst;
      fetch_pc      = pc;
      conveyor_stop = cs;
      jump_start    = js;
      #2;
      head = (mq.size() != 0) ? mq[0] : 64'd0;
      chk("count", 64'(count), 64'(mq.size()));
      chk("command_valid", 64'(command_valid), 64'(mq.size() != 0));
      chk("command", 64'(command), {32'd0, head[31:0]});
      chk("command_pc", 64'(command_pc), {32'd0, head[63:32]});
      chk("fetch_stop", 64'(fetch_stop), 64'((mq.size() >= DEPTH - 1) || cs));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
      full_m   = (mq.size() == DEPTH);
      did_pop  = (mq.size() != 0) && !cs && !js;
      did_push = fv && !full_m && !js;
      pop_val  = command;
      @(posedge clk);
      #1;
      if (fv && full_m) m_ovf = 1'b1;
      if (js) begin
         mq.delete();
      end else begin
         if (did_pop) void'(mq.pop_front());
         if (did_push) mq.push_back({pc, inst});
      end
      step_no++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        dp, du;
      logic [31:0] pv;
      logic [31:0] got[$];
      int          pushed;

      reset = 1'b0;
      fetch_valid = 1'b0;
      fetch_inst = '0;
      fetch_pc = '0;
      conveyor_stop = 1'b0;
      jump_start = 1'b0;
      m_ovf = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(command_valid), 64'd0);
      chk("rst_command", 64'(command), 64'd0);
      chk("rst_command_pc", 64'(command_pc), 64'd0);
      chk("rst_fetch_stop", 64'(fetch_stop), 64'd0);
      chk("rst_overflow", 64'(overflow_err), 64'd0);
      reset = 1'b1;

      // Streaming: each word appears at the head one cycle after its push
      step(1, 32'h11, 32'h0, 0, 0, dp, pv, du);
      chk("s_head11", 64'(command), 64'h11);
      step(1, 32'h22, 32'h4, 0, 0, dp, pv, du);
      chk("s_head22", 64'(command), 64'h22);
      chk("s_count1", 64'(count), 64'd1);
      step(1, 32'h33, 32'h8, 0, 0, dp, pv, du);
      chk("s_head33", 64'(command), 64'h33);
      chk("s_pc8", 64'(command_pc), 64'h8);
      step(0, 32'h0, 32'h0, 0, 0, dp, pv, du);
      chk("s_empty", 64'(command_valid), 64'd0);

      // Fill under stall, then drain in order
      for (int i = 0; i < 4; i++)
         step(1, 32'hA0 + 32'(i), 32'h20 + 32'(4 * i), 1, 0, dp, pv, du);
      chk("f_count4", 64'(count), 64'd4);
      chk("f_hold_a0", 64'(command), 64'hA0);
      for (int i = 0; i < 4; i++) begin
         step(0, 32'h0, 32'h0, 0, 0, dp, pv, du);
         chk("f_drain", 64'(pv), 64'(32'hA0 + 32'(i)));
      end
      chk("f_drained_valid", 64'(command_valid), 64'd0);
      chk("f_drained_cmd", 64'(command), 64'd0);

      // Push while full with a simultaneous pop: pop happens, push refused
      for (int i = 0; i < 4; i++)
         step(1, 32'hD0 + 32'(i), 32'h80 + 32'(4 * i), 1, 0, dp, pv, du);
      step(1, 32'hEE, 32'hFC, 0, 0, dp, pv, du);
      chk("o_count3", 64'(count), 64'd3);
      chk("o_overflow", 64'(overflow_err), 64'd1);
      chk("o_head_d1", 64'(command), 64'hD1);

      // Flush with a concurrent fetch: both suppressed, queue restarts at 0
      step(1, 32'hBB, 32'h3C, 0, 1, dp, pv, du);
      chk("j_count0", 64'(count), 64'd0);
      chk("j_valid0", 64'(command_valid), 64'd0);
      chk("j_overflow_kept", 64'(overflow_err), 64'd1);
      step(1, 32'hCC, 32'h40, 0, 0, dp, pv, du);
      chk("j_head_cc", 64'(command), 64'hCC);
      chk("j_pc40", 64'(command_pc), 64'h40);
      step(0, 32'h0, 32'h0, 1, 1, dp, pv, du);

      // Randomized interleave: ten words must come out exactly once, in order
      pushed = 0;
      for (int cyc = 0; cyc < 300 && (pushed < 10 || mq.size() != 0); cyc++) begin
         step((pushed < 10) && ($urandom_range(0, 1) == 1), 32'(pushed),
              32'h100 + 32'(4 * pushed), $urandom_range(0, 2) == 0, 0, dp, pv, du);
         if (dp) got.push_back(pv);
         if (du) pushed++;
      end
      chk("w_len", 64'(got.size()), 64'd10);
      for (int i = 0; i < got.size() && i < 10; i++)
         chk("w_order", 64'(got[i]), 64'(i));

      // Asynchronous reset in the middle of a burst
      step(1, 32'h71, 32'h200, 1, 0, dp, pv, du);
      step(1, 32'h72, 32'h204, 1, 0, dp, pv, du);
      chk("r_count2", 64'(count), 64'd2);
      conveyor_stop = 1'b0;
      fetch_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("r_async_count", 64'(count), 64'd0);
      chk("r_async_cmd", 64'(command), 64'd0);
      chk("r_async_valid", 64'(command_valid), 64'd0);
      chk("r_async_ovf", 64'(overflow_err), 64'd0);
      chk("r_async_stop", 64'(fetch_stop), 64'd0);
      mq.delete();
      m_ovf = 1'b0;
      #3;
      reset = 1'b1;
      @(posedge clk);
      #1;
      step(1, 32'h55, 32'h300, 0, 0, dp, pv, du);
      chk("r_after_head", 64'(command), 64'h55);
      step(0, 32'h0, 32'h0, 0, 0, dp, pv, du);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
